// File: rtl/avalon_fifo_bank_pkg.sv
// Shared address map and width helpers for the Avalon FIFO bank.
package fifo_bank_pkg;

    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_CH_BASE = 1;

    function automatic int addr_ovf(input int num_ch);
        return num_ch + 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/avalon_fifo_bank_if.sv
// Avalon-MM slave port plus the tagged valid/ready drain stream.
interface avalon_fifo_bank_if
    import fifo_bank_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int CH_W = ch_width(NUM_CH);

    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;

    modport master (
        output chipselect, write, read, address, writedata, out_ready,
        input  readdata, out_valid, out_data, out_ch
    );

    modport slave (
        input  chipselect, write, read, address, writedata, out_ready,
        output readdata, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/avalon_fifo_bank_sync_fifo.sv
// Single-channel synchronous FIFO; a push while full is dropped here and flagged by the parent.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_level == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/avalon_fifo_bank.sv
// Bank of NUM_CH FIFOs written over Avalon-MM, drained round-robin into one
// registered, channel-tagged valid/ready stream.
module avalon_fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3
) (
    input logic               clk,
    input logic               reset_n,
    avalon_fifo_bank_if.slave bus
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int LVL_W = lvl_width(DEPTH);

    logic                           w_wr_en;
    logic                           w_load;
    logic [NUM_CH-1:0]              w_push;
    logic [NUM_CH-1:0]              w_pop;
    logic [NUM_CH-1:0]              w_full;
    logic [NUM_CH-1:0]              w_empty;
    logic [NUM_CH-1:0]              w_clr;
    logic [NUM_CH-1:0][LVL_W-1:0]   w_level;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_fifo_data;
    logic                           w_found;
    logic [CH_W-1:0]                w_gnt;
    logic [DATA_W-1:0]              w_gnt_data;
    logic [DATA_W-1:0]              w_rd_val;
    int                             w_dist;
    int                             w_best;

    logic [NUM_CH-1:0]              r_ovf;
    logic [CH_W-1:0]                r_last;
    logic                           r_out_valid;
    logic [DATA_W-1:0]              r_out_data;
    logic [CH_W-1:0]                r_out_ch;
    logic [DATA_W-1:0]              r_readdata;

    assign w_wr_en = bus.chipselect && bus.write;
    assign w_load  = !r_out_valid || bus.out_ready;
    assign w_clr   = (w_wr_en && bus.address == ADDR_W'(ADDR_CTRL))
                   ? bus.writedata[NUM_CH-1:0] : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_push[c] = w_wr_en && (bus.address == ADDR_W'(ADDR_CH_BASE + c));
        assign w_pop[c]  = w_load && w_found && (w_gnt == CH_W'(c));

        sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .i_push  (w_push[c]),
            .i_data  (bus.writedata),
            .i_pop   (w_pop[c]),
            .o_data  (w_fifo_data[c]),
            .o_level (w_level[c]),
            .o_full  (w_full[c]),
            .o_empty (w_empty[c])
        );
    end

    // Round-robin: the non-empty channel closest after r_last wins.
    always_comb begin
        w_found    = 1'b0;
        w_gnt      = '0;
        w_gnt_data = '0;
        w_best     = NUM_CH;
        w_dist     = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_dist = (c + NUM_CH - 1 - int'(r_last)) % NUM_CH;
            if (!w_empty[c] && w_dist < w_best) begin
                w_best     = w_dist;
                w_found    = 1'b1;
                w_gnt      = CH_W'(c);
                w_gnt_data = w_fifo_data[c];
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (bus.address == ADDR_W'(ADDR_CTRL)) begin
            w_rd_val[NUM_CH-1:0] = ~w_empty;
        end else if (bus.address == ADDR_W'(addr_ovf(NUM_CH))) begin
            w_rd_val[NUM_CH-1:0] = r_ovf;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.address == ADDR_W'(ADDR_CH_BASE + c)) w_rd_val[LVL_W-1:0] = w_level[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf       <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_readdata  <= '0;
        end else begin
            if (bus.chipselect && bus.read) r_readdata <= w_rd_val;
            // A new overflow outranks a clear on the same edge.
            r_ovf <= (r_ovf & ~w_clr) | (w_push & w_full);
            if (w_load) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_data <= w_gnt_data;
                    r_out_ch   <= w_gnt;
                    r_last     <= w_gnt;
                end
            end
        end
    end

    assign bus.readdata  = r_readdata;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_avalon_fifo_bank.sv
// Directed bench for avalon_fifo_bank with a scoreboard on the drain stream.
module tb_avalon_fifo_bank;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_w;

    avalon_fifo_bank_if #(.NUM_CH(3), .DATA_W(8), .ADDR_W(3)) bus_if ();

    avalon_fifo_bank #(
        .NUM_CH (3),
        .DATA_W (8),
        .DEPTH  (4),
        .ADDR_W (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int ch, input logic [7:0] d);
        return (32'(ch) << 8) | 32'(d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
        bus_if.read       = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.address    = a;
        bus_if.writedata  = d;
        step();
        idle();
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] e);
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = a;
        step();
        idle();
        chk(tag, 32'(bus_if.readdata), 32'(e));
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while ((sb.size() != 0 || bus_if.out_valid) && cyc < 40) begin
            step();
            cyc++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Every accepted word is checked against the scoreboard in order.
    always @(negedge clk) begin
        if (reset_n && bus_if.out_valid && bus_if.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL out_extra: observed=%0h expected=none",
                       {bus_if.out_ch, bus_if.out_data});
            end else begin
                exp_w = sb.pop_front();
                chk("out_word", 32'({bus_if.out_ch, bus_if.out_data}), exp_w);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n          = 1'b0;
        bus_if.address   = '0;
        bus_if.writedata = '0;
        bus_if.out_ready = 1'b0;
        idle();
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset state
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        rd_check("rst_rd0", 3'd0, 8'h00);
        rd_check("rst_rd1", 3'd1, 8'h00);
        rd_check("rst_rd4", 3'd4, 8'h00);

        // Single word through channel 0
        bus_if.out_ready = 1'b1;
        sb.push_back(mk(0, 8'hA1));
        wr(3'd1, 8'hA1);
        rd_check("lvl_after_push", 3'd1, 8'd1);
        chk("a1_valid", 32'(bus_if.out_valid), 32'd1);
        chk("a1_data", 32'(bus_if.out_data), 32'hA1);
        chk("a1_ch", 32'(bus_if.out_ch), 32'd0);
        rd_check("lvl_after_pop", 3'd1, 8'd0);
        rd_check("unmapped_rd7", 3'd7, 8'h00);
        chk("idle_valid", 32'(bus_if.out_valid), 32'd0);

        // Fill channel 1 under backpressure and overflow it
        bus_if.out_ready = 1'b0;
        sb.push_back(mk(1, 8'h11));
        sb.push_back(mk(1, 8'h22));
        sb.push_back(mk(1, 8'h33));
        sb.push_back(mk(1, 8'h44));
        sb.push_back(mk(1, 8'h55));
        wr(3'd2, 8'h11);
        wr(3'd2, 8'h22);
        wr(3'd2, 8'h33);
        wr(3'd2, 8'h44);
        wr(3'd2, 8'h55);
        rd_check("lvl_full", 3'd2, 8'd4);
        rd_check("ovf_clear_pre", 3'd4, 8'h00);
        wr(3'd2, 8'h66);
        rd_check("ovf_set", 3'd4, 8'h02);
        rd_check("nonempty_mask", 3'd0, 8'h02);
        chk("bp_data", 32'(bus_if.out_data), 32'h11);
        chk("bp_ch", 32'(bus_if.out_ch), 32'd1);
        wr(3'd0, 8'h02);
        rd_check("ovf_w1c", 3'd4, 8'h00);
        bus_if.out_ready = 1'b1;
        wait_drain("drain_ch1");

        // Round-robin across three preloaded channels
        bus_if.out_ready = 1'b0;
        sb.push_back(mk(0, 8'h00));
        sb.push_back(mk(1, 8'h01));
        sb.push_back(mk(2, 8'h02));
        sb.push_back(mk(0, 8'h10));
        sb.push_back(mk(1, 8'h11));
        sb.push_back(mk(2, 8'h12));
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h01);
        wr(3'd3, 8'h02);
        wr(3'd1, 8'h10);
        wr(3'd2, 8'h11);
        wr(3'd3, 8'h12);
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_valid%0d", i), 32'(bus_if.out_valid), 32'd1);
            step();
        end
        chk("rr_sb_empty", 32'(sb.size()), 32'd0);
        chk("rr_done_valid", 32'(bus_if.out_valid), 32'd0);

        // Hold under backpressure, then reset mid-operation
        bus_if.out_ready = 1'b0;
        sb.push_back(mk(2, 8'h5A));
        wr(3'd3, 8'h5A);
        wr(3'd1, 8'h6B);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_valid%0d", i), 32'(bus_if.out_valid), 32'd1);
            chk($sformatf("hold_data%0d", i), 32'(bus_if.out_data), 32'h5A);
            chk($sformatf("hold_ch%0d", i), 32'(bus_if.out_ch), 32'd2);
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("async_rst_data", 32'(bus_if.out_data), 32'd0);
        chk("async_rst_ch", 32'(bus_if.out_ch), 32'd0);
        sb.delete();
        step();
        reset_n = 1'b1;
        step();
        rd_check("post_rst_lvl0", 3'd1, 8'd0);
        rd_check("post_rst_lvl1", 3'd2, 8'd0);
        rd_check("post_rst_lvl2", 3'd3, 8'd0);
        rd_check("post_rst_mask", 3'd0, 8'h00);
        chk("post_rst_valid", 32'(bus_if.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
